// File: rtl/pipelined_csel_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_csel_addsub
//
// Pipelined carry-select adder/subtractor with a valid/ready handshake and
// ALU flags. The WIDTH-bit datapath is cut into BLOCK-bit slices. Each slice
// precomputes its sum for carry-in 0 and carry-in 1, so the carry only passes
// through one select mux per slice. The slices are grouped into STAGES equal
// pipeline stages separated by registers.
//
// Add/subtract mode is resolved at the input: B is inverted and the carry-in
// forced to 1 for subtraction. Later stages only see plain operands plus a
// carry, so different modes can be interleaved freely.
//
// Ports
//   i_clk_1            clock, rising edge
//   i_rst_1            asynchronous reset, active-high; empties the pipeline
//   i_valid_1          input operation valid
//   o_ready_1          input accepted this cycle when high
//   i_adderOperand1_W  operand A
//   i_adderOperand2_W  operand B
//   i_sub_1            1: A-B, 0: A+B+i_cIn_1
//   i_cIn_1            carry-in, add mode only
//   o_valid_1          result valid
//   i_ready_1          downstream accepts the result
//   o_adderSum_W       sum/difference modulo 2^WIDTH
//   o_cOut_1           carry-out (sub mode: 1 = no borrow)
//   o_overflow_1       signed overflow
//   o_zero_1           result is zero
// -----------------------------------------------------------------------------
module pipelined_csel_addsub #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             i_clk_1,
   input  logic             i_rst_1,
   input  logic             i_valid_1,
   output logic             o_ready_1,
   input  logic [WIDTH-1:0] i_adderOperand1_W,
   input  logic [WIDTH-1:0] i_adderOperand2_W,
   input  logic             i_sub_1,
   input  logic             i_cIn_1,
   output logic             o_valid_1,
   input  logic             i_ready_1,
   output logic [WIDTH-1:0] o_adderSum_W,
   output logic             o_cOut_1,
   output logic             o_overflow_1,
   output logic             o_zero_1
);

   localparam int N   = WIDTH / BLOCK;   // number of slices
   localparam int SPS = N / STAGES;      // slices per stage
   localparam int SW  = SPS * BLOCK;     // bits per stage

   // One carry-select slice: both candidate results are formed from the
   // operands alone; the incoming carry only drives the final select.
   function automatic logic [BLOCK:0] csel_slice(input logic [BLOCK-1:0] a,
                                                 input logic [BLOCK-1:0] b,
                                                 input logic             cin);
      logic [BLOCK:0] r0;
      logic [BLOCK:0] r1;
      r0 = {1'b0, a} + {1'b0, b};
      r1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
      return cin ? r1 : r0;
   endfunction

   // Output register bank
   logic             vld_out_q;
   logic [WIDTH-1:0] sum_out_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   // A single global enable: every stage advances together or holds together,
   // so bubbles stay in place and nothing can be overwritten while stalled.
   logic en;
   assign en        = !vld_out_q || i_ready_1;
   assign o_ready_1 = en;

   genvar s;
   for (s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = s * SW;
      localparam int HI = LO + SW;

      logic [WIDTH-1:LO] a_in;      // operand bits not yet added
      logic [WIDTH-1:LO] b_in;      // already inverted for subtraction
      logic              c_in;
      logic              v_in;
      logic [HI-1:LO]    sum_d;     // bits produced by this stage
      logic              c_d;       // carry out of this stage
      logic [HI-1:0]     low_d;     // all completed sum bits so far

      // ---- stage input: from the ports or from the previous stage register
      if (s == 0) begin : g_first
         assign a_in  = i_adderOperand1_W;
         assign b_in  = i_sub_1 ? ~i_adderOperand2_W : i_adderOperand2_W;
         assign c_in  = i_sub_1 | i_cIn_1;
         assign v_in  = i_valid_1;
         assign low_d = sum_d;
      end else begin : g_next
         assign a_in  = g_stage[s-1].g_reg.a_q;
         assign b_in  = g_stage[s-1].g_reg.b_q;
         assign c_in  = g_stage[s-1].g_reg.c_q;
         assign v_in  = g_stage[s-1].g_reg.vld_q;
         assign low_d = {sum_d, g_stage[s-1].g_reg.sum_q};
      end

      // Carry ripples through the slice select muxes only.
      always_comb begin : p_slices
         logic           c;
         logic [BLOCK:0] r;
         c     = c_in;
         r     = '0;
         sum_d = '0;
         for (int k = 0; k < SPS; k++) begin
            r = csel_slice(a_in[LO + k*BLOCK +: BLOCK],
                           b_in[LO + k*BLOCK +: BLOCK], c);
            sum_d[LO + k*BLOCK +: BLOCK] = r[BLOCK-1:0];
            c = r[BLOCK];
         end
         c_d = c;
      end

      if (s < STAGES - 1) begin : g_reg
         // ---- stage boundary: completed low sum, stage carry, remaining operands
         logic [HI-1:0]    sum_q;
         logic [WIDTH-1:HI] a_q;
         logic [WIDTH-1:HI] b_q;
         logic             c_q;
         logic             vld_q;

         always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
            if (i_rst_1) begin
               sum_q <= '0;
               a_q   <= '0;
               b_q   <= '0;
               c_q   <= 1'b0;
               vld_q <= 1'b0;
            end else if (en) begin
               sum_q <= low_d;
               a_q   <= a_in[WIDTH-1:HI];
               b_q   <= b_in[WIDTH-1:HI];
               c_q   <= c_d;
               vld_q <= v_in;
            end
         end
      end else begin : g_out
         // ---- final boundary: full result and flags
         // The carry into the MSB is recovered from the MSB sum bit and its
         // operand bits, which avoids tapping the slice-internal carry chain.
         logic msb_cin;
         assign msb_cin = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ low_d[WIDTH-1];

         always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
            if (i_rst_1) begin
               sum_out_q <= '0;
               cout_q    <= 1'b0;
               ovf_q     <= 1'b0;
               zero_q    <= 1'b0;
               vld_out_q <= 1'b0;
            end else if (en) begin
               sum_out_q <= low_d;
               cout_q    <= c_d;
               ovf_q     <= msb_cin ^ c_d;
               zero_q    <= (low_d == '0);
               vld_out_q <= v_in;
            end
         end
      end
   end

   assign o_valid_1    = vld_out_q;
   assign o_adderSum_W = sum_out_q;
   assign o_cOut_1     = cout_q;
   assign o_overflow_1 = ovf_q;
   assign o_zero_1     = zero_q;

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_csel_addsub
//
// Drives four instances in parallel from one stimulus stream:
//   u0: WIDTH=32 BLOCK=4 STAGES=2   u1: BLOCK=4 STAGES=1
//   u2: BLOCK=4 STAGES=4            u3: BLOCK=8 STAGES=2
// Each instance has its own scoreboard queue of expected {cout, ovf, zero, sum}.
// -----------------------------------------------------------------------------
module tb_pipelined_csel_addsub;

   typedef logic [34:0] exp_t;   // {cout, ovf, zero, sum[31:0]}

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        vin;
   logic        rdy_in;
   logic        sub;
   logic        cin;
   logic [31:0] a;
   logic [31:0] b;

   logic [3:0]       rdy;
   logic [3:0]       ov;
   logic [3:0]       co;
   logic [3:0]       ovf;
   logic [3:0]       z;
   logic [3:0][31:0] sum;

   exp_t sbq [4][$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   pipelined_csel_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u0 (
      .i_clk_1(clk), .i_rst_1(rst), .i_valid_1(vin), .o_ready_1(rdy[0]),
      .i_adderOperand1_W(a), .i_adderOperand2_W(b), .i_sub_1(sub), .i_cIn_1(cin),
      .o_valid_1(ov[0]), .i_ready_1(rdy_in), .o_adderSum_W(sum[0]),
      .o_cOut_1(co[0]), .o_overflow_1(ovf[0]), .o_zero_1(z[0]));

   pipelined_csel_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(1)) u1 (
      .i_clk_1(clk), .i_rst_1(rst), .i_valid_1(vin), .o_ready_1(rdy[1]),
      .i_adderOperand1_W(a), .i_adderOperand2_W(b), .i_sub_1(sub), .i_cIn_1(cin),
      .o_valid_1(ov[1]), .i_ready_1(rdy_in), .o_adderSum_W(sum[1]),
      .o_cOut_1(co[1]), .o_overflow_1(ovf[1]), .o_zero_1(z[1]));

   pipelined_csel_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(4)) u2 (
      .i_clk_1(clk), .i_rst_1(rst), .i_valid_1(vin), .o_ready_1(rdy[2]),
      .i_adderOperand1_W(a), .i_adderOperand2_W(b), .i_sub_1(sub), .i_cIn_1(cin),
      .o_valid_1(ov[2]), .i_ready_1(rdy_in), .o_adderSum_W(sum[2]),
      .o_cOut_1(co[2]), .o_overflow_1(ovf[2]), .o_zero_1(z[2]));

   pipelined_csel_addsub #(.WIDTH(32), .BLOCK(8), .STAGES(2)) u3 (
      .i_clk_1(clk), .i_rst_1(rst), .i_valid_1(vin), .o_ready_1(rdy[3]),
      .i_adderOperand1_W(a), .i_adderOperand2_W(b), .i_sub_1(sub), .i_cIn_1(cin),
      .o_valid_1(ov[3]), .i_ready_1(rdy_in), .o_adderSum_W(sum[3]),
      .o_cOut_1(co[3]), .o_overflow_1(ovf[3]), .o_zero_1(z[3]));

   // Behavioural reference: 33-bit add, overflow from operand/result signs.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic s, input logic c);
      logic [31:0] yy;
      logic [32:0] full;
      logic        ci;
      logic        v;
      yy   = s ? ~y : y;
      ci   = s ? 1'b1 : c;
      full = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
      v    = (x[31] == yy[31]) && (full[31] != x[31]);
      return {full[32], v, (full[31:0] == 32'd0), full[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, want);
      end
   endtask

   function automatic exp_t outv(input int k);
      return {co[k], ovf[k], z[k], sum[k]};
   endfunction

   // One clock cycle. Called just after a falling edge with inputs driven;
   // transfers are evaluated before the rising edge, then waits to the next
   // falling edge.
   task automatic step(input exp_t e);
      exp_t x;
      #1;
      for (int k = 0; k < 4; k++) begin
         if (ov[k] && rdy_in) begin
            if (sbq[k].size() == 0) begin
               chk($sformatf("u%0d_unexpected_result", k), 64'(outv(k)), 64'h0);
               if (outv(k) == '0) begin
                  fails++;
                  $display("FAIL u%0d_unexpected_result: got valid output, expected none", k);
               end
            end else begin
               x = sbq[k].pop_front();
               chk($sformatf("u%0d_result", k), 64'(outv(k)), 64'(x));
            end
         end
         if (vin && rdy[k]) sbq[k].push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic c);
      a = x; b = y; sub = s; cin = c;
   endtask

   vec_t tv[10];
   int   lat[4];
   int   exp_lat[4] = '{2, 1, 4, 2};
   exp_t snap;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000}};
      tv[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF}};
      tv[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000}};
      tv[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}};
      tv[4] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000}};
      tv[5] = '{32'h0000_000F, 32'h0000_0000, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 32'h0000_0010}};
      tv[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 32'h0000_0007}};
      tv[7] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h2222_2221}};
      tv[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h0001_0000}};
      tv[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 1'b1, 32'h0000_0000}};

      rst = 1'b1; vin = 1'b0; rdy_in = 1'b1;
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("reset_valid", 64'(ov), 64'h0);
      for (int k = 0; k < 4; k++) chk($sformatf("u%0d_reset_outputs", k), 64'(outv(k)), 64'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 64'(rdy), 64'hF);
      @(negedge clk);

      // Latency of a single op with no stall
      drive(tv[0].a, tv[0].b, tv[0].sub, tv[0].cin);
      vin = 1'b1;
      step(tv[0].e);
      vin = 1'b0;
      lat = '{-1, -1, -1, -1};
      for (int cyc = 1; cyc <= 6; cyc++) begin
         #1;
         for (int k = 0; k < 4; k++) if (ov[k] && lat[k] < 0) lat[k] = cyc;
         step('0);
      end
      for (int k = 0; k < 4; k++) chk($sformatf("u%0d_latency", k), 64'(lat[k]), 64'(exp_lat[k]));

      // Directed vectors back-to-back, mixed modes
      for (int i = 0; i < 10; i++) begin
         drive(tv[i].a, tv[i].b, tv[i].sub, tv[i].cin);
         vin = 1'b1;
         step(tv[i].e);
      end
      vin = 1'b0;
      for (int i = 0; i < 6; i++) step('0);

      // Stream 4 ops, then stall downstream for 3 cycles while inputs keep changing
      rdy_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive($urandom, $urandom, 1'(i), 1'(i >> 1));
         vin = 1'b1;
         step(model(a, b, sub, cin));
      end
      rdy_in = 1'b0;
      #1;
      snap = outv(0);
      for (int i = 0; i < 3; i++) begin
         drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         vin = 1'b1;
         #1;
         chk("stall_ready", 64'(rdy[0]), 64'h0);
         chk("stall_valid", 64'(ov[0]), 64'h1);
         chk("stall_hold", 64'(outv(0)), 64'(snap));
         step(model(a, b, sub, cin));
      end
      rdy_in = 1'b1; vin = 1'b0;
      for (int i = 0; i < 6; i++) step('0);

      // Asynchronous reset with ops in flight
      for (int i = 0; i < 2; i++) begin
         drive($urandom, $urandom, 1'b0, 1'b1);
         vin = 1'b1;
         step(model(a, b, sub, cin));
      end
      vin = 1'b0;
      chk("pre_reset_valid", 64'(ov[0]), 64'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_valid", 64'(ov), 64'h0);
      chk("async_reset_sum", 64'(outv(0)), 64'h0);
      for (int k = 0; k < 4; k++) sbq[k].delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("post_reset_no_stale", 64'(ov), 64'h0);
         step('0);
      end

      // Random traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         drive(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         vin    = ($urandom_range(0, 3) != 0);
         rdy_in = ($urandom_range(0, 3) != 0);
         step(model(a, b, sub, cin));
      end
      vin = 1'b0; rdy_in = 1'b1;
      for (int i = 0; i < 10; i++) step('0);
      for (int k = 0; k < 4; k++) chk($sformatf("u%0d_drained", k), 64'(sbq[k].size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
